gpio_port_ex: RTL and testbench

Parametrised Avalon-MM parallel I/O port, successor to the fixed 32-bit expansion-header port. It adds a configurable width, a two-flop input synchroniser and per-bit glitch filter, and per-bit rising/falling edge-capture selection. It also adds atomic set/clear output registers, write-1-to-clear capture and byteenable-qualified writes. It sits between the Avalon slave fabric and a board header. The mapping of bits to header pins is done in the top level.

---
 rtl/gpio_port_ex_pkg.sv | 22 ++
 rtl/gpio_port_ex_if.sv | 23 ++
 rtl/gpio_in_filter.sv | 65 ++++++
 rtl/gpio_port_ex.sv | 133 +++++++++++++
 tb/tb_gpio_port_ex.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_port_ex_pkg.sv
// rtl/gpio_port_ex_pkg.sv - register map constants and helpers for gpio_port_ex
package gpio_port_ex_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] REG_DIRECTION = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IRQMASK   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_CAPTURE   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_OUTSET    = 3'd4;
    localparam logic [ADDR_W-1:0] REG_OUTCLR    = 3'd5;
    localparam logic [ADDR_W-1:0] REG_EDGE_RISE = 3'd6;
    localparam logic [ADDR_W-1:0] REG_EDGE_FALL = 3'd7;

    // Falling-edge capture on every bit out of reset, matching the older fixed port.
    localparam logic [31:0] EDGE_FALL_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_port_ex_if.sv
// rtl/gpio_port_ex_if.sv - Avalon-MM slave bus bundle for gpio_port_ex
interface gpio_port_ex_if;
    import gpio_port_ex_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata
    );

endinterface

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - one-bit input synchroniser and glitch filter
module gpio_in_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic filt_o,
    output logic filt_d_o
);

    logic meta_q;
    logic sync_q;
    logic filt;
    logic filt_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign filt = sync_q;
        end else begin : g_filter
            localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            logic [CW-1:0] cnt_q;
            logic          filt_q;

            // Accept a change only after FILTER_LEN consecutive disagreeing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else if (sync_q == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    filt_q <= sync_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d_q <= 1'b0;
        end else begin
            filt_d_q <= filt;
        end
    end

    assign filt_o   = filt;
    assign filt_d_o = filt_d_q;

endmodule

// File: rtl/gpio_port_ex.sv
// rtl/gpio_port_ex.sv - parametrised Avalon-MM GPIO port with filtered edge capture
module gpio_port_ex
    import gpio_port_ex_pkg::*;
#(
    parameter int W          = 32,
    parameter int FILTER_LEN = 4
) (
    input  logic           clk,
    input  logic           reset,
    gpio_port_ex_if.slave  bus,
    inout  wire  [W-1:0]   gpio,
    output logic           irq
);

    logic [W-1:0] data_q, data_d;
    logic [W-1:0] out_q;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] oe_q;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] cap_q, cap_d;
    logic [W-1:0] rise_en_q, rise_en_d;
    logic [W-1:0] fall_en_q, fall_en_d;
    logic [W-1:0] filt, filt_d;
    logic [W-1:0] cap_clr;
    logic [W-1:0] cap_new;
    logic [W-1:0] rd_w;
    logic [31:0]  rd_d;
    logic [31:0]  readdata_q;
    logic [31:0]  lanes;
    logic [W-1:0] wmask;
    logic [W-1:0] wdata;
    logic         we;
    logic         irq_q;
    logic         unused_read;

    assign unused_read = bus.read;
    assign lanes       = lane_mask(bus.byteenable);
    assign wmask       = lanes[W-1:0];
    assign wdata       = bus.writedata[W-1:0];
    assign we          = bus.chipselect & bus.write;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                           input logic [W-1:0] new_v,
                                           input logic [W-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    always_comb begin
        data_d    = data_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        cap_clr   = '0;
        if (we) begin
            case (bus.address)
                REG_DATA:      data_d    = merge(data_q, wdata, wmask);
                REG_DIRECTION: dir_d     = merge(dir_q, wdata, wmask);
                REG_IRQMASK:   mask_d    = merge(mask_q, wdata, wmask);
                REG_CAPTURE:   cap_clr   = wdata & wmask;
                REG_OUTSET:    data_d    = data_q | (wdata & wmask);
                REG_OUTCLR:    data_d    = data_q & ~(wdata & wmask);
                REG_EDGE_RISE: rise_en_d = merge(rise_en_q, wdata, wmask);
                REG_EDGE_FALL: fall_en_d = merge(fall_en_q, wdata, wmask);
                default:       cap_clr   = '0;
            endcase
        end
        // New edges are OR-ed in after the clear so a simultaneous edge wins.
        cap_new = (filt & ~filt_d & rise_en_q) | (~filt & filt_d & fall_en_q);
        cap_d   = (cap_q & ~cap_clr) | cap_new;
    end

    always_comb begin
        rd_w = '0;
        case (bus.address)
            REG_DATA:      rd_w = filt;
            REG_DIRECTION: rd_w = dir_q;
            REG_IRQMASK:   rd_w = mask_q;
            REG_CAPTURE:   rd_w = cap_q;
            REG_EDGE_RISE: rd_w = rise_en_q;
            REG_EDGE_FALL: rd_w = fall_en_q;
            default:       rd_w = '0;
        endcase
        rd_d         = '0;
        rd_d[W-1:0]  = rd_w;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            out_q      <= '0;
            dir_q      <= '0;
            oe_q       <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= EDGE_FALL_RST[W-1:0];
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q    <= data_d;
            out_q     <= data_q;
            dir_q     <= dir_d;
            oe_q      <= dir_q;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= |(cap_q & mask_q);
            if (bus.chipselect) begin
                readdata_q <= rd_d;
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

    for (genvar i = 0; i < W; i++) begin : g_pin
        assign gpio[i] = oe_q[i] ? out_q[i] : 1'bz;

        gpio_in_filter #(
            .FILTER_LEN (FILTER_LEN)
        ) u_filt (
            .clk      (clk),
            .rst_n    (reset),
            .pin_i    (gpio[i]),
            .filt_o   (filt[i]),
            .filt_d_o (filt_d[i])
        );
    end

endmodule

// File: tb/tb_gpio_port_ex.sv
// tb/tb_gpio_port_ex.sv - self-checking bench for gpio_port_ex
module tb_gpio_port_ex;
    import gpio_port_ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic [31:0] tb_en;
    logic [31:0] tb_val;
    wire  [31:0] gpio;

    always #5 clk = ~clk;

    gpio_port_ex_if bus();

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_port_ex #(.W(32), .FILTER_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .gpio  (gpio),
        .irq   (irq)
    );

    typedef struct {
        logic        do_wr;
        logic [2:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        tick();
        d              = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    function automatic logic [31:0] lanes_of(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] m_latch, m_old, bm, wd;
        logic [3:0]  be;
        int          op, len;

        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        tb_en          = 32'hFFFF_FFFF;
        tb_val         = 32'hA5A5_A5A5;
        reset          = 1'b1;
        #2 reset       = 1'b0;
        tick(3);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_pins_external", gpio, 32'hA5A5_A5A5);
        tb_val = 32'h0;
        reset  = 1'b1;
        tick(2);

        vecs.push_back('{1'b0, REG_DATA,      4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_DIRECTION, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_IRQMASK,   4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_CAPTURE,   4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_OUTSET,    4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_OUTCLR,    4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_EDGE_RISE, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b0, REG_EDGE_FALL, 4'hF, 32'h0,         32'hFFFF_FFFF});
        vecs.push_back('{1'b1, REG_DIRECTION, 4'b0010, 32'hFFFF_FFFF, 32'h0000_FF00});
        vecs.push_back('{1'b1, REG_DIRECTION, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b1, REG_IRQMASK,   4'b1001, 32'h1234_5678, 32'h1200_0078});
        vecs.push_back('{1'b1, REG_IRQMASK,   4'b0110, 32'hABCD_EF01, 32'h12CD_EF78});
        vecs.push_back('{1'b1, REG_EDGE_FALL, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b1, REG_EDGE_RISE, 4'b0100, 32'h00FF_FF00, 32'h00FF_0000});
        vecs.push_back('{1'b1, REG_EDGE_RISE, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b1, REG_OUTSET,    4'hF, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, REG_OUTCLR,    4'hF, 32'h0000_0000, 32'h0});
        vecs.push_back('{1'b1, REG_IRQMASK,   4'hF, 32'h0,         32'h0});

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].be, vecs[i].wd);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end

        // Latch is all ones but DIRECTION=0: pins must follow the external driver.
        tick(2);
        check("pins_released", gpio, 32'h0);
        bus_write(REG_DATA, 4'hF, 32'h0);

        tb_en = 32'hFFFF_FF00;
        bus_write(REG_DIRECTION, 4'hF, 32'h0000_00FF);
        tick(2);
        bus_write(REG_DATA, 4'hF, 32'h0000_000F);
        check("data_pin_before", gpio & 32'hFF, 32'h00);
        tick();
        check("data_pin_after", gpio & 32'hFF, 32'h0F);
        bus_write(REG_OUTSET, 4'hF, 32'h0000_0030);
        check("outset_pin_before", gpio & 32'hFF, 32'h0F);
        tick();
        check("outset_pin_after", gpio & 32'hFF, 32'h3F);
        bus_write(REG_OUTCLR, 4'hF, 32'h0000_0001);
        check("outclr_pin_before", gpio & 32'hFF, 32'h3F);
        tick();
        check("outclr_pin_after", gpio & 32'hFF, 32'h3E);

        // Random register traffic with the DUT driving every pin.
        m_latch = 32'h0000_003E;
        tb_en   = 32'h0;
        bus_write(REG_DIRECTION, 4'hF, 32'hFFFF_FFFF);
        tick(2);
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 6);
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            bm = lanes_of(be);
            m_old = m_latch;
            case (op)
                0: m_latch = (m_latch & ~bm) | (wd & bm);
                1: m_latch = m_latch | (wd & bm);
                2: m_latch = m_latch & ~(wd & bm);
                default: ;
            endcase
            if (op <= 2) begin
                bus_write(op == 0 ? REG_DATA : (op == 1 ? REG_OUTSET : REG_OUTCLR), be, wd);
                check("rnd_pin_hold", gpio, m_old);
                tick();
                check("rnd_pin_new", gpio, m_latch);
            end else if (op == 3) begin
                bus_write(REG_IRQMASK, be, wd);
            end else if (op == 4) begin
                bus_read(REG_OUTSET + 3'($urandom_range(0, 1)), rd);
                check("rnd_wo_read", rd, 32'h0);
            end else if (op == 5) begin
                bus_read(REG_CAPTURE, rd);
                check("rnd_capture", rd, 32'h0);
            end else begin
                bus_read(REG_DIRECTION, rd);
                check("rnd_dir", rd, 32'hFFFF_FFFF);
            end
            check("rnd_irq", {31'b0, irq}, 32'h0);
        end
        tick(8);
        bus_read(REG_DATA, rd);
        check("rnd_data_in", rd, m_latch);

        bus_write(REG_DATA, 4'hF, 32'h0);
        tick(2);
        tb_en  = 32'hFFFF_FFFF;
        tb_val = 32'h0;
        bus_write(REG_DIRECTION, 4'hF, 32'h0);
        bus_write(REG_IRQMASK, 4'hF, 32'h0);
        bus_write(REG_EDGE_RISE, 4'hF, 32'h0000_0004);
        tick(12);

        tb_val[2] = 1'b1;
        tick(3);
        tb_val[2] = 1'b0;
        tick(10);
        bus_read(REG_DATA, rd);
        check("glitch3_data", rd, 32'h0);
        bus_read(REG_CAPTURE, rd);
        check("glitch3_capture", rd, 32'h0);

        tb_val[2] = 1'b1;
        tick(4);
        tb_val[2] = 1'b0;
        tick();
        bus_read(REG_DATA, rd);
        check("pulse4_data_edge6", rd, 32'h0);
        bus_read(REG_DATA, rd);
        check("pulse4_data_edge7", rd, 32'h4);
        tick(10);
        bus_read(REG_CAPTURE, rd);
        check("pulse4_capture", rd, 32'h4);
        bus_write(REG_CAPTURE, 4'hF, 32'h4);
        bus_read(REG_CAPTURE, rd);
        check("pulse4_w1c", rd, 32'h0);

        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 7);
            tb_val[2] = 1'b1;
            tick(len);
            tb_val[2] = 1'b0;
            tick(12);
            bus_read(REG_CAPTURE, rd);
            check($sformatf("rnd_pulse_len%0d", len), rd, (len >= 4) ? 32'h4 : 32'h0);
            bus_write(REG_CAPTURE, 4'hF, 32'h4);
        end

        bus_write(REG_EDGE_RISE, 4'hF, 32'h1);
        bus_write(REG_IRQMASK, 4'hF, 32'h1);
        tick(2);
        tb_val[0] = 1'b1;
        tick(6);
        bus_read(REG_CAPTURE, rd);
        check("edge_cap_e7", rd, 32'h0);
        check("edge_irq_e7", {31'b0, irq}, 32'h0);
        bus_read(REG_CAPTURE, rd);
        check("edge_cap_e8", rd, 32'h1);
        check("edge_irq_e8", {31'b0, irq}, 32'h1);
        bus_write(REG_CAPTURE, 4'hF, 32'h1);
        check("w1c_irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check("w1c_irq_drop", {31'b0, irq}, 32'h0);

        tb_val[0] = 1'b0;
        tick(12);
        tb_val[0] = 1'b1;
        tick(6);
        bus_write(REG_CAPTURE, 4'hF, 32'h1);
        bus_read(REG_CAPTURE, rd);
        check("collision_capture", rd, 32'h1);
        check("collision_irq", {31'b0, irq}, 32'h1);

        #2 reset = 1'b0;
        #1;
        check("midreset_irq", {31'b0, irq}, 32'h0);
        check("midreset_readdata", bus.readdata, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        bus_read(REG_CAPTURE, rd);
        check("midreset_capture", rd, 32'h0);
        bus_read(REG_EDGE_FALL, rd);
        check("midreset_edge_fall", rd, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
